cpu_bus_ctrl: RTL and testbench

//  Parametrised memory-bus and status controller under the cpu top. Arbitrates instruction-fetch (IF)
//  and data-memory (DM) requests onto the single shared bus (readM/writeM/address/inout data).

---
 rtl/cpu_bus_ctrl_pkg.sv | 17 +
 rtl/cpu_bus_ctrl_bus_latency_timer.sv | 41 ++++
 rtl/cpu_bus_ctrl.sv | 143 ++++++++++++++
 tb/tb_cpu_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared definitions for the cpu memory-bus / status controller.
// Holds the default bus width, the bus FSM state encodings and the
// channel encoding used to remember which requester owns the bus.
package cpu_bus_ctrl_pkg;

   localparam int DEF_WORD_SIZE = 16;

   // Bus FSM state encodings
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   // Channel encodings
   localparam logic CH_IF = 1'b0;
   localparam logic CH_DM = 1'b1;

endpackage

// File: rtl/cpu_bus_ctrl_bus_latency_timer.sv
// bus_latency_timer: loadable down-counter that times one bus access.
// Ports:
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset, clears the count
//   load_i       load MEM_LATENCY (asserted on the grant cycle)
//   dec_i        decrement while the access is in progress
//   last_cycle_o high while the count equals 1, i.e. the final access cycle
module bus_latency_timer #(
   parameter int MEM_LATENCY = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load_i,
   input  logic dec_i,
   output logic last_cycle_o
);

   localparam int TW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = TW'(MEM_LATENCY);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - TW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_cycle_o = (cnt_q == TW'(1));

endmodule

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: arbitrates instruction-fetch (IF) and data-memory (DM)
// requests onto one shared memory bus with a configurable latency, and owns
// the cpu status outputs (num_inst, output_port, is_halted).
// Ports:
//   clk, reset_n                      clock / async active-low reset
//   if_req/if_addr -> if_ack/if_data  fetch channel
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_ack/dm_rdata   data channel
//   retire, wwd_valid/wwd_value, halt status inputs from the core
//   readM/writeM/address/data         shared memory bus (data is tri-state)
//   num_inst/output_port/is_halted    cpu status outputs
//   dbg_state                         current bus FSM state
// Handshake: a requester raises req (level) with its address/data and holds
// them until it sees its 1-cycle ack; the request is sampled once, on the
// grant cycle in IDLE. A req still high in the cycle after ack is a new request.
module cpu_bus_ctrl
   import cpu_bus_ctrl_pkg::*;
#(
   parameter int WORD_SIZE   = DEF_WORD_SIZE,
   parameter int MEM_LATENCY = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 if_req,
   input  logic [WORD_SIZE-1:0] if_addr,
   output logic                 if_ack,
   output logic [WORD_SIZE-1:0] if_data,
   input  logic                 dm_req,
   input  logic                 dm_we,
   input  logic [WORD_SIZE-1:0] dm_addr,
   input  logic [WORD_SIZE-1:0] dm_wdata,
   output logic                 dm_ack,
   output logic [WORD_SIZE-1:0] dm_rdata,
   input  logic                 retire,
   input  logic                 wwd_valid,
   input  logic [WORD_SIZE-1:0] wwd_value,
   input  logic                 halt,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   output logic [WORD_SIZE-1:0] num_inst,
   output logic [WORD_SIZE-1:0] output_port,
   output logic                 is_halted,
   output logic [1:0]           dbg_state
);

   logic [1:0]           state_q, state_d;
   logic                 ch_q;
   logic                 we_q;
   logic [WORD_SIZE-1:0] addr_q;
   logic [WORD_SIZE-1:0] wdata_q;
   logic [WORD_SIZE-1:0] if_data_q;
   logic [WORD_SIZE-1:0] dm_rdata_q;
   logic [WORD_SIZE-1:0] port_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 halted_q;

   logic grant;
   logic grant_dm;
   logic in_access;
   logic last_cycle;

   // DM wins over IF; nothing is granted once halted.
   assign grant     = (state_q == IDLE) && !halted_q && (dm_req || if_req);
   assign grant_dm  = dm_req;
   assign in_access = (state_q == ACCESS);

   bus_latency_timer #(
      .MEM_LATENCY (MEM_LATENCY)
   ) u_timer (
      .clk          (clk),
      .reset_n      (reset_n),
      .load_i       (grant),
      .dec_i        (in_access),
      .last_cycle_o (last_cycle)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant) state_d = ACCESS;
         ACCESS:  if (last_cycle) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ch_q       <= CH_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_data_q  <= '0;
         dm_rdata_q <= '0;
         port_q     <= '0;
         cnt_q      <= '0;
         halted_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            ch_q    <= grant_dm ? CH_DM : CH_IF;
            we_q    <= grant_dm && dm_we;
            addr_q  <= grant_dm ? dm_addr : if_addr;
            wdata_q <= dm_wdata;
         end
         // Load data is captured from the bus on the final access cycle.
         if (in_access && last_cycle && !we_q) begin
            if (ch_q == CH_DM) begin
               dm_rdata_q <= data;
            end else begin
               if_data_q <= data;
            end
         end
         // halted_q is still 0 in the halt cycle, so that cycle's retire/WWD count.
         if (retire && !halted_q) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end
         if (wwd_valid && !halted_q) begin
            port_q <= wwd_value;
         end
         if (halt) begin
            halted_q <= 1'b1;
         end
      end
   end

   assign readM       = in_access && !we_q;
   assign writeM      = in_access && we_q;
   assign address     = in_access ? addr_q : '0;
   assign data        = writeM ? wdata_q : 'z;
   assign if_ack      = (state_q == DONE) && (ch_q == CH_IF);
   assign dm_ack      = (state_q == DONE) && (ch_q == CH_DM);
   assign if_data     = if_data_q;
   assign dm_rdata    = dm_rdata_q;
   assign num_inst    = WORD_SIZE'(cnt_q);
   assign output_port = port_q;
   assign is_halted   = halted_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
module tb_cpu_bus_ctrl;
   import cpu_bus_ctrl_pkg::*;

   localparam int W = 16;

   logic          clk;
   logic          reset_n;
   logic          if_req, dm_req, dm_we, retire, wwd_valid, halt;
   logic [W-1:0]  if_addr, dm_addr, dm_wdata, wwd_value;
   logic          if_ack, dm_ack, readM, writeM, is_halted;
   logic [W-1:0]  if_data, dm_rdata, address, num_inst, output_port;
   logic [1:0]    dbg_state;
   wire  [W-1:0]  data;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   cpu_bus_ctrl #(.WORD_SIZE(W), .MEM_LATENCY(3), .CNT_WIDTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .retire(retire), .wwd_valid(wwd_valid), .wwd_value(wwd_value), .halt(halt),
      .readM(readM), .writeM(writeM), .address(address), .data(data),
      .num_inst(num_inst), .output_port(output_port), .is_halted(is_halted),
      .dbg_state(dbg_state)
   );

   // ---------------- memory model ----------------
   function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
      case (a)
         16'h0010: mem_word = 16'h6A05;
         16'h0020: mem_word = 16'h1357;
         16'h0050: mem_word = 16'hA5A5;
         default:  mem_word = 16'h0BAD;
      endcase
   endfunction

   // An undriven bus reads as all ones, so a released bus is observable.
   for (genvar g = 0; g < W; g++) begin : g_pu
      pullup (data[g]);
   end
   assign data = readM ? mem_word(address) : 'z;

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sb_pop(input string name, input logic [W-1:0] act);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: got %h with no expected entry", name, act);
      end else begin
         check(name, act, exp_q.pop_front());
      end
   endtask

   // ---------------- driver / monitor ----------------
   int rd_cnt, wr_cnt, if_ack_cyc, dm_ack_cyc, first_rd_cyc, first_wr_cyc;
   logic [W-1:0] exp_rd_addr, exp_wr_addr, exp_wdata;

   task automatic idle_inputs();
      if_req = 0; dm_req = 0; dm_we = 0; retire = 0; wwd_valid = 0; halt = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; wwd_value = '0;
   endtask

   task automatic sample_cycle(input int c);
      if (readM) begin
         rd_cnt++;
         if (first_rd_cyc == 0) first_rd_cyc = c;
         check("rd_addr", address, exp_rd_addr);
      end
      if (writeM) begin
         wr_cnt++;
         if (first_wr_cyc == 0) first_wr_cyc = c;
         check("wr_addr", address, exp_wr_addr);
         check("wr_data", data, exp_wdata);
         check("wr_no_rd", {15'd0, readM}, 16'd0);
      end
      if (if_ack) begin
         if_ack_cyc = c;
         if_req = 0;
         sb_pop("if_data", if_data);
      end
      if (dm_ack) begin
         dm_ack_cyc = c;
         if (!dm_we) sb_pop("dm_rdata", dm_rdata);
         dm_req = 0;
      end
   endtask

   // Cycle 1 is the cycle in which the caller applied the request.
   task automatic run_window(input int n, input int halt_cyc);
      rd_cnt = 0; wr_cnt = 0; if_ack_cyc = 0; dm_ack_cyc = 0;
      first_rd_cyc = 0; first_wr_cyc = 0;
      for (int c = 1; c <= n; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         sample_cycle(c);
         if (halt_cyc != 0) begin
            halt   = (c == halt_cyc);
            retire = (c == halt_cyc);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_readM"}, {15'd0, readM}, 16'd0);
      check({tag, "_writeM"}, {15'd0, writeM}, 16'd0);
      check({tag, "_if_ack"}, {15'd0, if_ack}, 16'd0);
      check({tag, "_dm_ack"}, {15'd0, dm_ack}, 16'd0);
      check({tag, "_address"}, address, 16'd0);
      check({tag, "_data_released"}, data, 16'hFFFF);
      check({tag, "_if_data"}, if_data, 16'd0);
      check({tag, "_dm_rdata"}, dm_rdata, 16'd0);
      check({tag, "_num_inst"}, num_inst, 16'd0);
      check({tag, "_output_port"}, output_port, 16'd0);
      check({tag, "_is_halted"}, {15'd0, is_halted}, 16'd0);
      check({tag, "_state"}, {14'd0, dbg_state}, {14'd0, IDLE});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         retire;
      logic         wwd_valid;
      logic [W-1:0] wwd_value;
      logic [W-1:0] exp_num;
      logic [W-1:0] exp_port;
   } vec_t;

   vec_t vecs[20];

   initial begin
      int n_run;
      logic [W-1:0] port_run;

      n_run = 0;
      port_run = '0;
      for (int i = 0; i < 20; i++) begin
         vecs[i].retire    = (i < 17);
         vecs[i].wwd_valid = (i == 0) || (i == 9);
         vecs[i].wwd_value = (i == 0) ? 16'h1234 : (i == 9) ? 16'h00AB : 16'hDEAD;
         if (vecs[i].retire) n_run = (n_run + 1) % 16;
         if (vecs[i].wwd_valid) port_run = vecs[i].wwd_value;
         vecs[i].exp_num  = n_run[W-1:0];
         vecs[i].exp_port = port_run;
      end

      // ---- reset ----
      idle_inputs();
      reset_n = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst0");
      reset_n = 1;
      @(posedge clk); #1;

      // ---- fetch, latency 3 ----
      exp_rd_addr = 16'h0010;
      if_addr = 16'h0010; if_req = 1;
      exp_q.push_back(16'h6A05);
      run_window(8, 0);
      check("fetch_rd_cycles", rd_cnt[W-1:0], 16'd3);
      check("fetch_first_rd", first_rd_cyc[W-1:0], 16'd2);
      check("fetch_ack_cycle", if_ack_cyc[W-1:0], 16'd5);
      check("fetch_if_data_held", if_data, 16'h6A05);

      // ---- arbitration: store beats fetch ----
      exp_wr_addr = 16'h0040; exp_wdata = 16'hBEEF; exp_rd_addr = 16'h0020;
      if_addr = 16'h0020; if_req = 1;
      dm_addr = 16'h0040; dm_wdata = 16'hBEEF; dm_we = 1; dm_req = 1;
      exp_q.push_back(16'h1357);
      run_window(14, 0);
      check("arb_first_wr", first_wr_cyc[W-1:0], 16'd2);
      check("arb_wr_cycles", wr_cnt[W-1:0], 16'd3);
      check("arb_dm_ack", dm_ack_cyc[W-1:0], 16'd5);
      check("arb_first_rd", first_rd_cyc[W-1:0], 16'd7);
      check("arb_rd_cycles", rd_cnt[W-1:0], 16'd3);
      check("arb_if_ack", if_ack_cyc[W-1:0], 16'd10);
      dm_we = 0;

      // ---- DM load ----
      exp_rd_addr = 16'h0050;
      dm_addr = 16'h0050; dm_we = 0; dm_req = 1;
      exp_q.push_back(16'hA5A5);
      run_window(8, 0);
      check("load_rd_cycles", rd_cnt[W-1:0], 16'd3);
      check("load_dm_ack", dm_ack_cyc[W-1:0], 16'd5);
      check("load_if_data_held", if_data, 16'h1357);

      // ---- status vectors: retire count wrap and WWD ----
      for (int i = 0; i < 20; i++) begin
         retire = vecs[i].retire;
         wwd_valid = vecs[i].wwd_valid;
         wwd_value = vecs[i].wwd_value;
         @(posedge clk); #1;
         check($sformatf("vec%0d_num_inst", i), num_inst, vecs[i].exp_num);
         check($sformatf("vec%0d_output_port", i), output_port, vecs[i].exp_port);
      end
      retire = 0; wwd_valid = 0;
      check("wrap_after_17", num_inst, 16'd1);

      // ---- reset in the middle of a store ----
      dm_addr = 16'h0040; dm_wdata = 16'h5555; dm_we = 1; dm_req = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_writeM", {15'd0, writeM}, 16'd1);
      check("pre_rst_data", data, 16'h5555);
      reset_n = 0;
      #1;
      check_reset_outputs("rst1");
      idle_inputs();
      @(posedge clk); #1;
      reset_n = 1;
      @(posedge clk); #1;

      // ---- halt with retire during a fetch ----
      exp_rd_addr = 16'h0010;
      if_addr = 16'h0010; if_req = 1;
      exp_q.push_back(16'h6A05);
      run_window(8, 2);
      check("halt_rd_cycles", rd_cnt[W-1:0], 16'd3);
      check("halt_if_ack", if_ack_cyc[W-1:0], 16'd5);
      check("halt_num_inst", num_inst, 16'd1);
      check("halt_is_halted", {15'd0, is_halted}, 16'd1);

      // ---- requests and retires after halt ----
      if_req = 1; dm_req = 1; dm_we = 1; retire = 1;
      run_window(10, 0);
      check("halted_no_rd", rd_cnt[W-1:0], 16'd0);
      check("halted_no_wr", wr_cnt[W-1:0], 16'd0);
      check("halted_no_if_ack", if_ack_cyc[W-1:0], 16'd0);
      check("halted_no_dm_ack", dm_ack_cyc[W-1:0], 16'd0);
      check("halted_num_inst", num_inst, 16'd1);
      check("halted_sticky", {15'd0, is_halted}, 16'd1);
      idle_inputs();

      check("sb_drained", exp_q.size(), 16'd0);

      // ---- final report ----
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
